muxdecod_varredura: RTL and testbench

- Sequential sweep controller for the 7-bit-in / 1-bit-out muxdecod lookup block.
- Drives muxdecod's Entrada through a programmable code range [cod_ini..cod_fim], one code per clock.
- Samples muxdecod's Saida for each code and accumulates:
  - the count of codes that give 1 (minterms),
  - the first and last code that gives 1.
- Used to check muxdecod in hardware and to extract its truth table on the board; sits beside muxdecod and owns its input bus.

---
 rtl/muxdecod_pkg.sv | 18 +
 rtl/acumulador_minterm.sv | 53 +++++
 rtl/muxdecod_varredura.sv | 141 ++++++++++++++
 tb/tb_muxdecod_varredura.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/muxdecod_pkg.sv
// Shared definitions for the muxdecod sweep controller: default widths and
// the controller state encoding.
package muxdecod_pkg;

    // Width of the muxdecod input code.
    localparam int N_BITS_MD = 7;

    // Width of the minterm counter; one bit wider than the code so that a
    // full-range sweep (2**N_BITS codes) can never saturate it.
    localparam int CONT_W_MD = 8;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        VARRE  = 2'd1,
        FIM    = 2'd2
    } estado_t;

endpackage : muxdecod_pkg

// File: rtl/acumulador_minterm.sv
// Minterm accumulator: counts the codes for which muxdecod answered 1 and
// remembers the lowest and highest such code seen since the last clear.
module acumulador_minterm #(
    parameter int N_BITS = 7,
    parameter int CONT_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              limpar_i,
    input  logic              amostrar_i,
    input  logic              bit_i,
    input  logic [N_BITS-1:0] codigo_i,
    output logic [CONT_W-1:0] contagem_o,
    output logic              achou_o,
    output logic [N_BITS-1:0] primeiro_o,
    output logic [N_BITS-1:0] ultimo_o
);

    logic [CONT_W-1:0] contagem_q;
    logic              achou_q;
    logic [N_BITS-1:0] primeiro_q;
    logic [N_BITS-1:0] ultimo_q;

    // Clear on request, otherwise fold in one sampled muxdecod answer.
    // NOTE: non-blocking assignments so every register sees pre-edge values
    // (achou_q below is the old value, which is what gates primeiro_q).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contagem_q <= '0;
            achou_q    <= 1'b0;
            primeiro_q <= '0;
            ultimo_q   <= '0;
        end else if (limpar_i) begin
            contagem_q <= '0;
            achou_q    <= 1'b0;
            primeiro_q <= '0;
            ultimo_q   <= '0;
        end else if (amostrar_i && bit_i) begin
            contagem_q <= contagem_q + 1'b1;
            ultimo_q   <= codigo_i;
            if (!achou_q) begin
                primeiro_q <= codigo_i;
                achou_q    <= 1'b1;
            end
        end
    end

    assign contagem_o = contagem_q;
    assign achou_o    = achou_q;
    assign primeiro_o = primeiro_q;
    assign ultimo_o   = ultimo_q;

endmodule : acumulador_minterm

// File: rtl/muxdecod_varredura.sv
// Sweep controller for muxdecod: walks Entrada through [cod_ini..cod_fim],
// one code per clock, and collects minterm statistics from Saida_md.
module muxdecod_varredura
    import muxdecod_pkg::*;
#(
    parameter int N_BITS = N_BITS_MD,
    parameter int CONT_W = CONT_W_MD
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abortar,
    input  logic [N_BITS-1:0] cod_ini,
    input  logic [N_BITS-1:0] cod_fim,
    output logic [N_BITS-1:0] Entrada,
    input  logic              Saida_md,
    output logic              busy,
    output logic              done,
    output logic              valido,
    output logic              erro,
    output logic [CONT_W-1:0] contagem,
    output logic              achou,
    output logic [N_BITS-1:0] primeiro,
    output logic [N_BITS-1:0] ultimo
);

    estado_t           estado_q, estado_d;
    logic [N_BITS-1:0] entrada_q, entrada_d;
    logic [N_BITS-1:0] fim_q, fim_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              valido_q, valido_d;
    logic              erro_q, erro_d;
    logic              limpar;
    logic              amostrar;

    // State, code counter, latched range end and status flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q  <= OCIOSO;
            entrada_q <= '0;
            fim_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valido_q  <= 1'b0;
            erro_q    <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            entrada_q <= entrada_d;
            fim_q     <= fim_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            valido_q  <= valido_d;
            erro_q    <= erro_d;
        end
    end

    // Next-state logic: start handling, per-code stepping, abort and finish.
    // NOTE: every signal gets a default first so no path through the case
    // leaves one unassigned, which would infer a latch.
    always_comb begin
        estado_d  = estado_q;
        entrada_d = entrada_q;
        fim_d     = fim_q;
        done_d    = 1'b0;
        valido_d  = valido_q;
        erro_d    = erro_q;
        limpar    = 1'b0;
        amostrar  = 1'b0;

        unique case (estado_q)
            OCIOSO: begin
                // abortar is ignored here, so start wins when both are high.
                if (start) begin
                    limpar   = 1'b1;
                    valido_d = 1'b0;
                    if (cod_ini <= cod_fim) begin
                        fim_d     = cod_fim;
                        entrada_d = cod_ini;
                        erro_d    = 1'b0;
                        estado_d  = VARRE;
                    end else begin
                        // Empty range: report immediately, Entrada untouched.
                        erro_d = 1'b1;
                        done_d = 1'b1;
                    end
                end
            end
            VARRE: begin
                if (abortar) begin
                    // The code on Entrada during the abort cycle is not
                    // sampled; results so far are kept but marked invalid.
                    valido_d = 1'b0;
                    estado_d = OCIOSO;
                end else begin
                    amostrar = 1'b1;
                    if (entrada_q == fim_q) begin
                        // Hold the last code; 2**N_BITS-1 never wraps to 0.
                        estado_d = FIM;
                    end else begin
                        entrada_d = entrada_q + 1'b1;
                    end
                end
            end
            FIM: begin
                done_d   = 1'b1;
                valido_d = 1'b1;
                estado_d = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase

        // busy follows the state one edge later, so it falls as done rises.
        busy_d = (estado_d != OCIOSO);
    end

    acumulador_minterm #(
        .N_BITS (N_BITS),
        .CONT_W (CONT_W)
    ) u_acumulador (
        .clock      (clock),
        .reset      (reset),
        .limpar_i   (limpar),
        .amostrar_i (amostrar),
        .bit_i      (Saida_md),
        .codigo_i   (entrada_q),
        .contagem_o (contagem),
        .achou_o    (achou),
        .primeiro_o (primeiro),
        .ultimo_o   (ultimo)
    );

    assign Entrada = entrada_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign valido  = valido_q;
    assign erro    = erro_q;

endmodule : muxdecod_varredura

// File: tb/tb_muxdecod_varredura.sv
// Directed bench for muxdecod_varredura with a behavioural muxdecod beside it.
module tb_muxdecod_varredura;
    import muxdecod_pkg::*;

    localparam int NB = N_BITS_MD;
    localparam int CW = CONT_W_MD;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abortar = 1'b0;
    logic [NB-1:0] cod_ini = '0;
    logic [NB-1:0] cod_fim = '0;
    logic [NB-1:0] Entrada;
    logic          Saida_md;
    logic          busy, done, valido, erro, achou;
    logic [CW-1:0] contagem;
    logic [NB-1:0] primeiro, ultimo;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    muxdecod_varredura dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .abortar  (abortar),
        .cod_ini  (cod_ini),
        .cod_fim  (cod_fim),
        .Entrada  (Entrada),
        .Saida_md (Saida_md),
        .busy     (busy),
        .done     (done),
        .valido   (valido),
        .erro     (erro),
        .contagem (contagem),
        .achou    (achou),
        .primeiro (primeiro),
        .ultimo   (ultimo)
    );

    // muxdecod: 8:1 mux selected by code[6:4], 16 codes per select.
    // Ones at 0..15, 16..17, 32..47, 80..95 -> 50 minterms, first 0, last 95.
    function automatic logic modelo(input logic [NB-1:0] c);
        case (c[6:4])
            3'd0, 3'd2, 3'd5: return 1'b1;
            3'd1:             return (c[3:1] == 3'd0);
            default:          return 1'b0;
        endcase
    endfunction

    assign Saida_md = modelo(Entrada);

    task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nome, got, exp);
        end
    endtask

    typedef struct {
        string         nome;
        logic [NB-1:0] ini;
        logic [NB-1:0] fim;
        int            lat;     // negedges after the start edge until done
        logic [CW-1:0] cont;
        logic          achou;
        logic [NB-1:0] prim;
        logic [NB-1:0] ult;
        logic [NB-1:0] entr;    // Entrada after the sweep
        logic          valido;
        logic          erro;
    } vetor_t;

    vetor_t tab[7];

    // Launch one start and check latency, busy profile and results.
    task automatic run(input vetor_t v);
        int   n;
        logic busy_ok;
        @(negedge clock);
        cod_ini = v.ini;
        cod_fim = v.fim;
        start   = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start   = 1'b0;
        n       = 0;
        busy_ok = 1'b1;
        while (!done && n < 300) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clock);
            n++;
        end
        check({v.nome, " latency"},  n, v.lat);
        check({v.nome, " busy run"}, busy_ok, 1);
        check({v.nome, " busy@done"}, busy, 0);
        check({v.nome, " valido"},   valido, v.valido);
        check({v.nome, " erro"},     erro, v.erro);
        check({v.nome, " contagem"}, contagem, v.cont);
        check({v.nome, " achou"},    achou, v.achou);
        check({v.nome, " primeiro"}, primeiro, v.prim);
        check({v.nome, " ultimo"},   ultimo, v.ult);
        check({v.nome, " Entrada"},  Entrada, v.entr);
        @(negedge clock);
        check({v.nome, " done pulse"}, done, 0);
    endtask

    // Wait (bounded) until Entrada shows the given code at a negedge.
    task automatic wait_code(input logic [NB-1:0] c, input string nome);
        int n = 0;
        while (Entrada != c && n < 300) begin
            @(negedge clock);
            n++;
        end
        check({nome, " reached"}, (Entrada == c), 1);
    endtask

    initial begin
        //         nome        ini  fim  lat  cont achou prim ult entr val err
        tab[0] = '{"full",       0, 127, 129, 50,  1,    0,  95, 127, 1, 0};
        tab[1] = '{"17..33",    17,  33,  18,  3,  1,   17,  33,  33, 1, 0};
        tab[2] = '{"48..79",    48,  79,  33,  0,  0,    0,   0,  79, 1, 0};
        tab[3] = '{"reversed",  10,   5,   0,  0,  0,    0,   0,  79, 0, 1};
        tab[4] = '{"127..127", 127, 127,   2,  0,  0,    0,   0, 127, 1, 0};
        tab[5] = '{"0..0",       0,   0,   2,  1,  1,    0,   0,   0, 1, 0};
        tab[6] = '{"94..97",    94,  97,   5,  2,  1,   94,  95,  97, 1, 0};

        #1 reset = 1'b1;
        #2;
        check("reset outputs",
              {Entrada, busy, done, valido, erro, contagem, achou, primeiro, ultimo}, 0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) run(tab[i]);

        // Abort at Entrada=40 with an ignored start issued at Entrada=20.
        @(negedge clock);
        cod_ini = 0;
        cod_fim = 127;
        start   = 1'b1;
        @(negedge clock);
        start   = 1'b0;
        wait_code(20, "abort 20");
        cod_ini = 100;
        cod_fim = 110;
        start   = 1'b1;
        @(negedge clock);
        start   = 1'b0;
        wait_code(40, "abort 40");
        abortar = 1'b1;
        @(negedge clock);
        abortar = 1'b0;
        check("abort busy",     busy, 0);
        check("abort valido",   valido, 0);
        check("abort contagem", contagem, 26);   // codes 0..17 and 32..39
        check("abort primeiro", primeiro, 0);
        check("abort ultimo",   ultimo, 39);
        check("abort Entrada",  Entrada, 40);
        begin
            logic seen = 1'b0;
            for (int k = 0; k < 6; k++) begin
                if (done) seen = 1'b1;
                @(negedge clock);
            end
            check("abort no done", seen, 0);
        end

        // Asynchronous reset in the middle of a sweep.
        cod_ini = 0;
        cod_fim = 127;
        start   = 1'b1;
        @(negedge clock);
        start   = 1'b0;
        wait_code(64, "reset 64");
        #2 reset = 1'b1;
        #1;
        check("midreset outputs",
              {Entrada, busy, done, valido, erro, contagem, achou, primeiro, ultimo}, 0);
        check("midreset contagem", contagem, 0);
        @(negedge clock);
        reset = 1'b0;
        run(tab[4]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_muxdecod_varredura
